// File: rtl/seq_arith_unit_if.sv
// Operand/result bundle between operand capture logic and the arithmetic unit.
// Carries the start request, opcode and operands, plus the registered result side.
// The master drives start/op/a/b; the slave returns result/overflow/busy/done.
interface seq_arith_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, overflow, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, overflow, busy, done
    );
endinterface

// File: rtl/seq_arith_unit.sv
// Two's-complement add/sub/negate/multiply unit with optional saturation.
// Latency: add/sub/negate 1 cycle; multiply WIDTH+2 cycles (shift-add, LSB first).
// Backpressure: start is only honoured while idle; requests during busy are dropped.
module seq_arith_unit #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    seq_arith_unit_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    localparam logic [WIDTH-1:0]   MAXV    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   MINV    = {1'b1, {(WIDTH-1){1'b0}}};
    // Largest product magnitudes that still fit: 2^(W-1) when negative, 2^(W-1)-1 when positive.
    localparam logic [2*WIDTH-1:0] LIM_NEG = {{WIDTH{1'b0}}, MINV};
    localparam logic [2*WIDTH-1:0] LIM_POS = LIM_NEG - (2*WIDTH)'(1);

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               sign;

    logic [WIDTH-1:0]   sum, diff, neg, abs_a, abs_b;
    logic [WIDTH-1:0]   q_res;
    logic               q_ovf, q_true_neg;
    logic               p_neg, m_ovf;
    logic [WIDTH-1:0]   m_res;

    // Single-cycle ops: raw result, overflow, and sign of the true result for clamping.
    always_comb begin
        sum        = bus.a + bus.b;
        diff       = bus.a - bus.b;
        neg        = WIDTH'(0) - bus.a;
        abs_a      = bus.a[MSB] ? neg : bus.a;
        abs_b      = bus.b[MSB] ? (WIDTH'(0) - bus.b) : bus.b;
        q_res      = '0;
        q_ovf      = 1'b0;
        q_true_neg = 1'b0;
        case (bus.op)
            2'b00: begin
                q_res      = sum;
                q_ovf      = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
                q_true_neg = bus.a[MSB];
            end
            2'b01: begin
                q_res      = diff;
                q_ovf      = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
                q_true_neg = bus.a[MSB];
            end
            2'b11: begin
                // Only -MIN overflows, and its true value is positive.
                q_res      = neg;
                q_ovf      = (bus.a == MINV);
                q_true_neg = 1'b0;
            end
            default: begin
                q_res      = '0;
                q_ovf      = 1'b0;
                q_true_neg = 1'b0;
            end
        endcase
        if (SATURATE && q_ovf) begin
            q_res = q_true_neg ? MINV : MAXV;
        end
    end

    // Multiply finish: signed product from magnitude; a zero product is never negative.
    always_comb begin
        p_neg = sign && (acc != '0);
        m_ovf = acc > (p_neg ? LIM_NEG : LIM_POS);
        // Low bits of -acc only depend on low bits of acc.
        m_res = p_neg ? (WIDTH'(0) - acc[MSB:0]) : acc[MSB:0];
        if (SATURATE && m_ovf) begin
            m_res = p_neg ? MINV : MAXV;
        end
    end

    // Control FSM with registered result/overflow/busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            sign         <= 1'b0;
            bus.result   <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == 2'b10) begin
                            mcand    <= {{WIDTH{1'b0}}, abs_a};
                            mplier   <= abs_b;
                            sign     <= bus.a[MSB] ^ bus.b[MSB];
                            acc      <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= MUL;
                        end else begin
                            bus.result   <= q_res;
                            bus.overflow <= q_ovf;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    bus.result   <= m_res;
                    bus.overflow <= m_ovf;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed and random checks of seq_arith_unit at WIDTH 8/16, wrap and saturate.
// All four variants see the same stimulus; expected values come from constants
// and a 64-bit signed reference model.
module tb_seq_arith_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_arith_unit_if #(.WIDTH(8))  if0 ();
    seq_arith_unit_if #(.WIDTH(8))  if1 ();
    seq_arith_unit_if #(.WIDTH(16)) if2 ();
    seq_arith_unit_if #(.WIDTH(16)) if3 ();

    seq_arith_unit #(.WIDTH(8),  .SATURATE(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    seq_arith_unit #(.WIDTH(8),  .SATURATE(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    seq_arith_unit #(.WIDTH(16), .SATURATE(1'b0)) u2 (.clk(clk), .reset(reset), .bus(if2));
    seq_arith_unit #(.WIDTH(16), .SATURATE(1'b1)) u3 (.clk(clk), .reset(reset), .bus(if3));

    logic [31:0] rs [4];
    logic        dn [4];
    logic        bz [4];
    logic        ov [4];
    assign rs[0] = 32'(if0.result);
    assign rs[1] = 32'(if1.result);
    assign rs[2] = 32'(if2.result);
    assign rs[3] = 32'(if3.result);
    assign dn[0] = if0.done;  assign dn[1] = if1.done;
    assign dn[2] = if2.done;  assign dn[3] = if3.done;
    assign bz[0] = if0.busy;  assign bz[1] = if1.busy;
    assign bz[2] = if2.busy;  assign bz[3] = if3.busy;
    assign ov[0] = if0.overflow;  assign ov[1] = if1.overflow;
    assign ov[2] = if2.overflow;  assign ov[3] = if3.overflow;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ndone [4];
    int          nbusy [4];
    int          lat   [4];
    logic [31:0] cres  [4];
    logic        cov   [4];

    function automatic int width_of(input int k);
        return (k < 2) ? 8 : 16;
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 1) || (k == 3);
    endfunction

    // Reference: exact signed result in 64 bits, then range check and wrap/clamp.
    function automatic void model(input int w, input bit sat, input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic v);
        longint m, sa, sb, t;
        logic [63:0] tu;
        m  = longint'(1) << w;
        sa = longint'({32'd0, x}) & (m - 1);
        sb = longint'({32'd0, y}) & (m - 1);
        if (sa >= m / 2) sa = sa - m;
        if (sb >= m / 2) sb = sb - m;
        case (o)
            2'b00:   t = sa + sb;
            2'b01:   t = sa - sb;
            2'b10:   t = sa * sb;
            default: t = -sa;
        endcase
        v = (t > m / 2 - 1) || (t < -(m / 2));
        if (sat && v) t = (t > 0) ? (m / 2 - 1) : -(m / 2);
        tu = 64'(t & (m - 1));
        r  = tu[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if0.start = s; if0.op = o; if0.a = x[7:0];  if0.b = y[7:0];
        if1.start = s; if1.op = o; if1.a = x[7:0];  if1.b = y[7:0];
        if2.start = s; if2.op = o; if2.a = x[15:0]; if2.b = y[15:0];
        if3.start = s; if3.op = o; if3.a = x[15:0]; if3.b = y[15:0];
    endtask

    // Start pulse spanning one rising edge (edge 0); operands are scrambled afterwards.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        drive(1'b1, o, x, y);
        @(negedge clk);
        drive(1'b0, ~o, ~x, ~y);
    endtask

    // Sample n times at falling edges; first sample is the current falling edge.
    task automatic collect(input int n);
        for (int k = 0; k < 4; k++) begin
            ndone[k] = 0; nbusy[k] = 0; lat[k] = -1; cres[k] = '0; cov[k] = 1'b0;
        end
        for (int c = 1; c <= n; c++) begin
            if (c > 1) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (dn[k]) begin
                    ndone[k]++;
                    lat[k]  = c - 1;
                    cres[k] = rs[k];
                    cov[k]  = ov[k];
                end
                if (bz[k]) nbusy[k]++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er;
        logic        eo;
        int          w;
        issue(o, x, y);
        collect((o == 2'b10) ? 19 : 2);
        for (int k = 0; k < 4; k++) begin
            w = width_of(k);
            model(w, sat_of(k), o, x, y, er, eo);
            chk($sformatf("%s/u%0d/ndone", tag, k), 32'(ndone[k]), 32'd1);
            chk($sformatf("%s/u%0d/lat", tag, k), 32'(lat[k]), (o == 2'b10) ? 32'(w + 1) : 32'd0);
            chk($sformatf("%s/u%0d/busy", tag, k), 32'(nbusy[k]), (o == 2'b10) ? 32'(w + 1) : 32'd0);
            chk($sformatf("%s/u%0d/res", tag, k), cres[k], er);
            chk($sformatf("%s/u%0d/ovf", tag, k), 32'(cov[k]), 32'(eo));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y;

        reset = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        #12;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst/u%0d/res", k),  rs[k], 32'd0);
            chk($sformatf("rst/u%0d/ovf", k),  32'(ov[k]), 32'd0);
            chk($sformatf("rst/u%0d/busy", k), 32'(bz[k]), 32'd0);
            chk($sformatf("rst/u%0d/done", k), 32'(dn[k]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors, hand-computed for WIDTH=8.
        run_op("add100p50", 2'b00, 32'd100, 32'd50);
        chk("add100p50/wrap_res", cres[0], 32'h96);
        chk("add100p50/wrap_ovf", 32'(cov[0]), 32'd1);
        chk("add100p50/sat_res",  cres[1], 32'h7F);
        chk("add100p50/sat_ovf",  32'(cov[1]), 32'd1);

        run_op("subm128m1", 2'b01, 32'hFFFF_FF80, 32'd1);
        chk("subm128m1/res", cres[0], 32'h7F);
        chk("subm128m1/ovf", 32'(cov[0]), 32'd1);

        run_op("sub5mm3", 2'b01, 32'd5, 32'hFFFF_FFFD);
        chk("sub5mm3/res", cres[0], 32'h08);
        chk("sub5mm3/ovf", 32'(cov[0]), 32'd0);

        run_op("mul7xm9", 2'b10, 32'd7, 32'hFFFF_FFF7);
        chk("mul7xm9/res",  cres[0], 32'hC1);
        chk("mul7xm9/ovf",  32'(cov[0]), 32'd0);
        chk("mul7xm9/lat",  32'(lat[0]), 32'd9);
        chk("mul7xm9/busy", 32'(nbusy[0]), 32'd9);

        run_op("mulm12x11", 2'b10, 32'hFFFF_FFF4, 32'd11);
        chk("mulm12x11/wrap_res", cres[0], 32'h7C);
        chk("mulm12x11/wrap_ovf", 32'(cov[0]), 32'd1);
        chk("mulm12x11/sat_res",  cres[1], 32'h80);
        chk("mulm12x11/sat_ovf",  32'(cov[1]), 32'd1);

        run_op("mulm8xm16", 2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFF0);
        chk("mulm8xm16/wrap_res", cres[0], 32'h80);
        chk("mulm8xm16/wrap_ovf", 32'(cov[0]), 32'd1);
        chk("mulm8xm16/sat_res",  cres[1], 32'h7F);
        chk("mulm8xm16/sat_ovf",  32'(cov[1]), 32'd1);

        run_op("mul0xm5", 2'b10, 32'd0, 32'hFFFF_FFFB);
        chk("mul0xm5/res", cres[0], 32'h00);
        chk("mul0xm5/ovf", 32'(cov[0]), 32'd0);

        run_op("negm128", 2'b11, 32'hFFFF_FF80, 32'd0);
        chk("negm128/wrap_res", cres[0], 32'h80);
        chk("negm128/wrap_ovf", 32'(cov[0]), 32'd1);
        chk("negm128/sat_res",  cres[1], 32'h7F);
        chk("negm128/sat_ovf",  32'(cov[1]), 32'd1);

        // Start re-pulsed at edge 3 of a multiply must be ignored.
        @(negedge clk);
        drive(1'b1, 2'b10, 32'd7, 32'hFFFF_FFF7);
        @(negedge clk);
        drive(1'b0, 2'b10, 32'd7, 32'hFFFF_FFF7);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 2'b00, 32'd1, 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd1, 32'd1);
        collect(20);
        chk("ignore/u0/ndone", 32'(ndone[0]), 32'd1);
        chk("ignore/u0/res",   cres[0], 32'hC1);
        chk("ignore/u2/ndone", 32'(ndone[2]), 32'd1);
        chk("ignore/u2/res",   cres[2], 32'hFFC1);

        // Start during the done cycle is accepted and completes one cycle later.
        issue(2'b10, 32'd3, 32'd5);
        for (int c = 0; c < 20 && !dn[0]; c++) @(negedge clk);
        chk("b2b/first_done", 32'(dn[0]), 32'd1);
        chk("b2b/first_res",  rs[0], 32'd15);
        drive(1'b1, 2'b00, 32'd2, 32'd3);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd2, 32'd3);
        chk("b2b/second_done", 32'(dn[0]), 32'd1);
        chk("b2b/second_res",  rs[0], 32'd5);
        @(negedge clk);
        chk("b2b/done_drop", 32'(dn[0]), 32'd0);
        collect(20);
        chk("b2b/u2/ndone", 32'(ndone[2]), 32'd1);
        chk("b2b/u2/res",   cres[2], 32'd15);

        // Asynchronous reset in the middle of a multiply.
        issue(2'b10, 32'd7, 32'hFFFF_FFF7);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst/u%0d/res", k),  rs[k], 32'd0);
            chk($sformatf("midrst/u%0d/ovf", k),  32'(ov[k]), 32'd0);
            chk($sformatf("midrst/u%0d/busy", k), 32'(bz[k]), 32'd0);
            chk($sformatf("midrst/u%0d/done", k), 32'(dn[k]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        collect(25);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst/u%0d/no_done", k), 32'(ndone[k]), 32'd0);
        end

        // Random ops with occasional extreme operands.
        for (int i = 0; i < 500; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'hFFFF_FF80;
                1: y = 32'hFFFF_8000;
                2: x = 32'h0000_7FFF;
                3: y = 32'h0000_0000;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), o, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised, clocked two's-complement arithmetic unit that generalises the lab's 8-bit add/subtract-with-overflow datapath to WIDTH bits. It adds negate and an iterative signed multiply, an optional saturating mode, and a start/busy/done handshake. It sits between the switch/UART operand capture logic and the LED/UART result path. Result and overflow flag are registered and held until the next completion.

## Interface
- WIDTH, 8: operand/result width in bits, legal range 4..32.
- SATURATE, 0: 0 = wrap on overflow (keep low WIDTH bits); 1 = clamp to most-positive/most-negative on overflow.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only on a rising edge while idle.
- op  input  2  00 add (a+b), 01 sub (a−b), 10 signed multiply (a×b), 11 negate (−a).
- a  input  WIDTH  signed operand A; sampled with start.
- b  input  WIDTH  signed operand B; sampled with start, ignored for op 11.
- result  output  WIDTH  signed result, registered.
- overflow  output  1  registered; 1 when the true result is not representable in WIDTH signed bits.
- busy  output  1  1 while a multiply is in progress.
- done  output  1  one-cycle pulse when result/overflow update.

## Operation
- States: IDLE, MUL, FIN.
- IDLE, start=0: hold all outputs; done=0.
- IDLE, start=1, op∈{00,01,11}:
  - compute in one cycle and register result, overflow and done=1;
  - stay IDLE.
- IDLE, start=1, op=10:
  - latch |a| and |b| as WIDTH-bit unsigned (most-negative maps to 2^(WIDTH−1));
  - latch sign = a[MSB]^b[MSB];
  - clear the 2·WIDTH-bit accumulator and the iteration counter; go to MUL.
- MUL: each cycle shift-add one multiplier bit (LSB first). Move to FIN after exactly WIDTH iterations.
- FIN:
  - apply sign to the 2·WIDTH-bit magnitude product p;
  - overflow = p outside [−2^(WIDTH−1), 2^(WIDTH−1)−1];
  - result = p[WIDTH−1:0], or the clamped value;
  - done=1; go to IDLE.
- Overflow rules:
  - add: operands same sign and result sign differs.
  - sub: operand signs differ and result sign differs from a.
  - negate: a = 100…0.
  - multiply: as in FIN.
- Saturation (SATURATE=1, overflow=1):
  - clamp to 011…1 if the true result is positive, 100…0 if negative;
  - negate of most-negative gives 011…1.
- Zero product is never negative: 0×(−x) gives result 0, overflow 0.
- start while busy=1 is ignored. Operand/op changes during MUL have no effect.
- result/overflow change only on a done cycle or reset.

## Timing
- Reset (asynchronous, immediate): result=0, overflow=0, busy=0, done=0, state IDLE, accumulator and counter cleared.
- Reset during MUL aborts the operation; no done pulse is produced.
- Sampling edge = edge 0.
- add/sub/negate: result, overflow and done visible after edge 0. Latency 1 cycle; busy stays 0.
- multiply:
  - busy=1 after edge 0;
  - result/overflow/done visible after edge WIDTH+1;
  - busy=0 in the same cycle done=1.
- done is high for exactly one cycle per accepted start.
- Back-to-back: start=1 during the done cycle is accepted, since the unit is IDLE. One operation is accepted per cycle for non-multiply ops.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=8, SATURATE=0:
  - add a=100, b=50 → result 0x96 (−106), overflow 1, done after 1 edge.
  - sub a=−128, b=1 → result 0x7F, overflow 1.
  - sub a=5, b=−3 → result 8, overflow 0.
- WIDTH=8 multiply, SATURATE=0:
  - a=7, b=−9 → result 0xC1 (−63), overflow 0, busy high 9 cycles.
  - done pulses exactly 9 edges after the sampling edge.
  - a=−12, b=11 → result 0x7C, overflow 1.
  - a=−8, b=−16 → result 0x80, overflow 1.
  - a=0, b=−5 → result 0, overflow 0.
- WIDTH=8, SATURATE=1:
  - mul −12×11 → 0x80, overflow 1.
  - mul −8×−16 → 0x7F, overflow 1.
  - add 100+50 → 0x7F, overflow 1.
  - negate −128 → 0x7F, overflow 1.
- Handshake, WIDTH=8:
  - start a mul; re-pulse start with op=00 at edge 3 → ignored; only one done, with the mul result.
  - start=1 during the done cycle with op=00 → accepted; done again on the next cycle.
- Reset mid-multiply: assert reset asynchronously at edge 4 of a mul → result 0, overflow 0, busy 0, done 0 immediately; no later done.
- Randomised: WIDTH=8 and WIDTH=16, 500 random op/a/b per SATURATE setting, checked against a 2·WIDTH-bit signed reference model; zero mismatches.
